// File: rtl/exec_stage_mc_if.sv
// rtl/exec_stage_mc_if.sv - operand/control/result bundle for exec_stage_mc; SRout widens with EXEC_OVERFLOW_FLAG_EN
interface exec_stage_mc_if #(
  parameter int WIDTH = 16
);
`ifdef EXEC_OVERFLOW_FLAG_EN
  localparam int SR_W = 3;
`else
  localparam int SR_W = 2;
`endif

  logic [WIDTH-1:0] MDRout;
  logic [WIDTH-1:0] immGenOut;
  logic [WIDTH-1:0] CCout;
  logic [WIDTH-1:0] reggieOut;
  logic [1:0]       ALUsrcA;
  logic [1:0]       ALUsrcB;
  logic [2:0]       ALUop;
  logic             start;
  logic             ALU_in;
  logic             SRw;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUoutputVal;
  logic [SR_W-1:0]  SRout;

  modport master (
    output MDRout, immGenOut, CCout, reggieOut, ALUsrcA, ALUsrcB, ALUop,
    output start, ALU_in, SRw,
    input  busy, done, ALUoutputVal, SRout
  );

  modport slave (
    input  MDRout, immGenOut, CCout, reggieOut, ALUsrcA, ALUsrcB, ALUop,
    input  start, ALU_in, SRw,
    output busy, done, ALUoutputVal, SRout
  );
endinterface

// File: rtl/exec_stage_mc.sv
// rtl/exec_stage_mc.sv - multi-cycle execute stage: src muxes, 8-op ALU, bit-serial shifter, ALU/SR registers
// Optional EXEC_OVERFLOW_FLAG_EN adds a signed-overflow V bit to SRout ({Z,N,V}).
module exec_stage_mc #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic          CLK,
  input  logic          reset,
  exec_stage_mc_if.slave bus
);
`ifdef EXEC_OVERFLOW_FLAG_EN
  localparam int SR_W = 3;
`else
  localparam int SR_W = 2;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]          shop_q, shop_d;
  logic                alu_in_q, alu_in_d;
  logic                srw_q, srw_d;
  logic [WIDTH-1:0]    alu_out_q, alu_out_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic                done_q, done_d;

  logic [WIDTH-1:0]    a_val, b_val, alu_res, shift_next, fin_res;
  logic [SHAMT_W-1:0]  sh;
  logic                is_shift, accept_shift, last_shift;
  logic                fin_en, fin_alu, fin_sr;
  logic [SR_W-1:0]     sr_new;
`ifdef EXEC_OVERFLOW_FLAG_EN
  logic                alu_ovf, fin_v;
`endif

  always_comb begin
    a_val = '0;
    case (bus.ALUsrcA)
      2'b00:   a_val = bus.MDRout;
      2'b01:   a_val = bus.immGenOut;
      2'b10:   a_val = bus.CCout;
      default: a_val = '0;
    endcase
    b_val = WIDTH'(1);
    case (bus.ALUsrcB)
      2'b00:   b_val = WIDTH'(1);
      2'b01:   b_val = bus.reggieOut;
      2'b10:   b_val = bus.immGenOut;
      default: b_val = bus.MDRout;
    endcase
  end

  assign sh           = a_val[SHAMT_W-1:0];
  assign is_shift     = bus.ALUop[2] && (bus.ALUop[1:0] != 2'b11);
  assign accept_shift = bus.start && is_shift && (sh != '0);
  assign last_shift   = (cnt_q == SHAMT_W'(1));

  // Shift ops only reach this path with sh==0, where the result is B itself.
  always_comb begin
    alu_res = '0;
    case (bus.ALUop)
      3'b000:  alu_res = a_val + b_val;
      3'b001:  alu_res = a_val & b_val;
      3'b010:  alu_res = a_val | b_val;
      3'b011:  alu_res = b_val - a_val;
      3'b111:  alu_res = a_val;
      default: alu_res = b_val;
    endcase
  end

`ifdef EXEC_OVERFLOW_FLAG_EN
  always_comb begin
    alu_ovf = 1'b0;
    case (bus.ALUop)
      3'b000:  alu_ovf = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (alu_res[WIDTH-1] != a_val[WIDTH-1]);
      3'b011:  alu_ovf = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (alu_res[WIDTH-1] != b_val[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  always_comb begin
    shift_next = work_q >> 1;
    case (shop_q)
      2'b00:   shift_next = work_q << 1;
      2'b01:   shift_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_next = work_q >> 1;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      shop_q    <= '0;
      alu_in_q  <= 1'b0;
      srw_q     <= 1'b0;
      alu_out_q <= '0;
      sr_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      shop_q    <= shop_d;
      alu_in_q  <= alu_in_d;
      srw_q     <= srw_d;
      alu_out_q <= alu_out_d;
      sr_q      <= sr_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_shift) state_d = S_SHIFT;
      S_SHIFT: if (last_shift)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Completion source: single-cycle op accepted in IDLE, or final shift step.
  always_comb begin
    fin_en  = 1'b0;
    fin_res = alu_res;
    fin_alu = bus.ALU_in;
    fin_sr  = bus.SRw;
`ifdef EXEC_OVERFLOW_FLAG_EN
    fin_v   = alu_ovf;
`endif
    if (state_q == S_IDLE) begin
      fin_en = bus.start && !accept_shift;
    end else begin
      fin_en  = last_shift;
      fin_res = shift_next;
      fin_alu = alu_in_q;
      fin_sr  = srw_q;
`ifdef EXEC_OVERFLOW_FLAG_EN
      fin_v   = 1'b0;
`endif
    end
  end

`ifdef EXEC_OVERFLOW_FLAG_EN
  assign sr_new = {(fin_res == '0), fin_res[WIDTH-1], fin_v};
`else
  assign sr_new = {(fin_res == '0), fin_res[WIDTH-1]};
`endif

  // Datapath register updates
  always_comb begin
    work_d    = work_q;
    cnt_d     = cnt_q;
    shop_d    = shop_q;
    alu_in_d  = alu_in_q;
    srw_d     = srw_q;
    alu_out_d = alu_out_q;
    sr_d      = sr_q;
    done_d    = fin_en;
    if (state_q == S_IDLE) begin
      if (accept_shift) begin
        work_d   = b_val;
        cnt_d    = sh;
        shop_d   = bus.ALUop[1:0];
        alu_in_d = bus.ALU_in;
        srw_d    = bus.SRw;
      end
    end else begin
      work_d = shift_next;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
    if (fin_en && fin_alu) alu_out_d = fin_res;
    if (fin_en && fin_sr)  sr_d      = sr_new;
  end

  // Outputs
  always_comb begin
    bus.busy         = (state_q == S_SHIFT);
    bus.done         = done_q;
    bus.ALUoutputVal = alu_out_q;
    bus.SRout        = sr_q;
  end
endmodule

// File: tb/tb_exec_stage_mc.sv
// tb/tb_exec_stage_mc.sv - self-checking bench for exec_stage_mc against a behavioural operation model
module tb_exec_stage_mc;
  localparam int WIDTH = 16;
`ifdef EXEC_OVERFLOW_FLAG_EN
  localparam int SR_W = 3;
`else
  localparam int SR_W = 2;
`endif

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  exec_stage_mc_if #(.WIDTH(WIDTH)) bus ();
  exec_stage_mc #(.WIDTH(WIDTH), .SHAMT_W(4)) dut (.CLK(CLK), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] m_alu;
  logic [SR_W-1:0]  m_sr;
  int               m_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: operation semantics with plain arithmetic and full-width shifts.
  task automatic model_op(input logic [2:0] op, input logic ai, input logic sw);
    logic [WIDTH-1:0] a, b, r;
    int sh, wide;
    logic v;
    case (bus.ALUsrcA)
      2'd0: a = bus.MDRout;
      2'd1: a = bus.immGenOut;
      2'd2: a = bus.CCout;
      default: a = '0;
    endcase
    case (bus.ALUsrcB)
      2'd0: b = 16'd1;
      2'd1: b = bus.reggieOut;
      2'd2: b = bus.immGenOut;
      default: b = bus.MDRout;
    endcase
    sh = int'(a[3:0]);
    v = 1'b0;
    m_lat = 1;
    wide = 0;
    case (op)
      3'd0: begin r = a + b; wide = int'($signed(a)) + int'($signed(b)); v = (wide > 32767) || (wide < -32768); end
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: begin r = b - a; wide = int'($signed(b)) - int'($signed(a)); v = (wide > 32767) || (wide < -32768); end
      3'd4: begin r = b << sh; m_lat = sh + 1; end
      3'd5: begin r = $signed(b) >>> sh; m_lat = sh + 1; end
      3'd6: begin r = b >> sh; m_lat = sh + 1; end
      default: r = a;
    endcase
    if (ai) m_alu = r;
`ifdef EXEC_OVERFLOW_FLAG_EN
    if (sw) m_sr = {r == 16'd0, r[15], v};
`else
    if (sw) m_sr = {r == 16'd0, r[15]};
`endif
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] op,
                        input logic ai, input logic sw, input bit poke);
    int lat;
    bus.ALUsrcA = sa; bus.ALUsrcB = sb; bus.ALUop = op; bus.ALU_in = ai; bus.SRw = sw;
    model_op(op, ai, sw);
    bus.start = 1'b1;
    @(posedge CLK); @(negedge CLK);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat <= WIDTH + 2) begin
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      bus.MDRout = 16'($urandom); bus.immGenOut = 16'($urandom);
      bus.CCout = 16'($urandom); bus.reggieOut = 16'($urandom);
      bus.ALUsrcA = 2'($urandom); bus.ALUsrcB = 2'($urandom); bus.ALUop = 3'($urandom);
      bus.ALU_in = 1'($urandom); bus.SRw = 1'($urandom);
      bus.start = poke;
      @(posedge CLK); @(negedge CLK);
      bus.start = 1'b0;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(m_lat));
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, " alu"}, 32'(bus.ALUoutputVal), 32'(m_alu));
    check({tag, " sr"}, 32'(bus.SRout), 32'(m_sr));
    @(posedge CLK); @(negedge CLK);
    check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    bit seen_done;
    bus.MDRout = '0; bus.immGenOut = '0; bus.CCout = '0; bus.reggieOut = '0;
    bus.ALUsrcA = '0; bus.ALUsrcB = '0; bus.ALUop = '0;
    bus.start = 1'b1; bus.ALU_in = 1'b1; bus.SRw = 1'b1;
    m_alu = '0; m_sr = '0; m_lat = 1;
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset alu", 32'(bus.ALUoutputVal), 32'd0);
    check("reset sr", 32'(bus.SRout), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    reset = 1'b0;

    bus.MDRout = 16'hABCD; bus.reggieOut = 16'hABCD;
    run_op("sub_zero", 2'b00, 2'b01, 3'b011, 1'b1, 1'b1, 1'b0);
    check("sub_zero lit alu", 32'(bus.ALUoutputVal), 32'h0000);
    check("sub_zero lit sr", 32'(bus.SRout), (SR_W == 3) ? 32'h4 : 32'h2);

    bus.immGenOut = 16'h0005;
    run_op("add_one", 2'b01, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0);
    check("add_one lit alu", 32'(bus.ALUoutputVal), 32'h0006);

    bus.immGenOut = 16'h7FFF; bus.reggieOut = 16'h0001;
    run_op("add_ovf", 2'b01, 2'b01, 3'b000, 1'b1, 1'b1, 1'b0);
    check("add_ovf lit alu", 32'(bus.ALUoutputVal), 32'h8000);

    bus.immGenOut = 16'h0004; bus.reggieOut = 16'h8010;
    run_op("sra4", 2'b01, 2'b01, 3'b101, 1'b1, 1'b1, 1'b1);
    check("sra4 lit alu", 32'(bus.ALUoutputVal), 32'hF801);

    bus.immGenOut = 16'h0000; bus.reggieOut = 16'h1234;
    run_op("sll0", 2'b01, 2'b01, 3'b100, 1'b1, 1'b1, 1'b0);
    check("sll0 lit alu", 32'(bus.ALUoutputVal), 32'h1234);

    bus.immGenOut = 16'h000F; bus.reggieOut = 16'h0001;
    run_op("sll15", 2'b01, 2'b01, 3'b100, 1'b1, 1'b0, 1'b0);
    check("sll15 lit alu", 32'(bus.ALUoutputVal), 32'h8000);

    // Reset during the third SHIFT cycle of an 8-step SRL.
    bus.immGenOut = 16'h0008; bus.reggieOut = 16'hF0F0;
    bus.ALUsrcA = 2'b01; bus.ALUsrcB = 2'b01; bus.ALUop = 3'b110; bus.ALU_in = 1'b1; bus.SRw = 1'b1;
    bus.start = 1'b1;
    @(posedge CLK); @(negedge CLK);
    bus.start = 1'b0;
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    check("abort busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge CLK); @(negedge CLK);
    reset = 1'b0;
    m_alu = '0; m_sr = '0;
    check("abort alu", 32'(bus.ALUoutputVal), 32'd0);
    check("abort sr", 32'(bus.SRout), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done || bus.busy) seen_done = 1'b1;
      @(posedge CLK); @(negedge CLK);
    end
    check("abort no_done", 32'(seen_done), 32'd0);
    bus.CCout = 16'h00AA;
    run_op("pass_cc", 2'b10, 2'b00, 3'b111, 1'b1, 1'b1, 1'b0);
    check("pass_cc lit alu", 32'(bus.ALUoutputVal), 32'h00AA);

    // Back-to-back single-cycle ops: one result per cycle.
    bus.ALUsrcA = 2'b01; bus.ALUsrcB = 2'b00; bus.ALUop = 3'b000; bus.ALU_in = 1'b1; bus.SRw = 1'b1;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.immGenOut = 16'($urandom);
      model_op(3'b000, 1'b1, 1'b1);
      @(posedge CLK); @(negedge CLK);
      check("b2b done", 32'(bus.done), 32'd1);
      check("b2b alu", 32'(bus.ALUoutputVal), 32'(m_alu));
      check("b2b sr", 32'(bus.SRout), 32'(m_sr));
    end
    bus.start = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("b2b done_end", 32'(bus.done), 32'd0);

    for (int n = 0; n < 80; n++) begin
      bus.MDRout = 16'($urandom); bus.immGenOut = 16'($urandom);
      bus.CCout = 16'($urandom); bus.reggieOut = 16'($urandom);
      run_op("rand", 2'($urandom), 2'($urandom), 3'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), bit'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
